// File: rtl/fw_cmd_sequencer_pkg.sv
// Shared types, status bit map and helpers for the firmware command sequencer.
package fw_cmd_sequencer_pkg;

  typedef enum logic [3:0] {
    firmware_id_none = 4'd0,
    firmware_id_1    = 4'd1,
    firmware_id_2    = 4'd2,
    firmware_id_3    = 4'd3
  } firmware_id_t;

  typedef enum logic [3:0] {
    OP_CODE_NOOP              = 4'd0,
    OP_CODE_W_RST_FW          = 4'd1,
    OP_CODE_IP_LAST           = 4'd13,
    OP_CODE_W_STATUS_FW_CLEAR = 4'd14,
    OP_CODE_W_EXECUTE         = 4'd15
  } op_code_t;

  typedef enum logic [1:0] {
    IDLE_CS,
    DECODE_CS,
    ISSUE_CS,
    WAIT_DONE_CS
  } state_t_sm_cmd_seq;

  localparam int status_index_op_code_w_reset      = 0;
  localparam int status_index_execute_done         = 13;
  localparam int status_index_test_done_base       = 14;
  localparam int status_index_spare_min            = 18;
  localparam int status_index_spare_max            = 29;
  localparam int status_index_error_timeout        = 30;
  localparam int status_index_error_w_execute_cfg  = 31;

  localparam logic [31:0] STATUS_SPARE_MASK = 32'h3FFC_0000;

  function automatic logic one_hot4(input logic [3:0] v);
    case (v)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fw_cmd_sequencer.sv
// Accepts firmware command words, strobes the addressed IP and tracks
// completion, timeout and test results in a sticky status word.
module fw_cmd_sequencer
  import fw_cmd_sequencer_pkg::*;
#(
  parameter logic [3:0]  FIRMWARE_ID    = firmware_id_1,
  parameter int          TEST_NUM_LSB   = 14,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        fw_axi_clk,
  input  logic        fw_rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_word,
  output logic [15:0] op_start,
  output logic [23:0] op_body,
  input  logic        op_done,
  input  logic [3:0]  test_done,
  output logic [31:0] status,
  output logic        busy
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t_sm_cmd_seq state;
  logic [3:0]  dev_id;
  logic [3:0]  op_code;
  logic [15:0] wait_cnt;
  logic [3:0]  test_field;
  logic        for_me;
  logic        exec_bad;
  logic        status_clear;
  logic [31:0] status_set;

  assign test_field = op_body[TEST_NUM_LSB +: 4];
  assign for_me     = (dev_id == FIRMWARE_ID) && (dev_id != firmware_id_none);
  assign exec_bad   = (op_code == OP_CODE_W_EXECUTE) && !one_hot4(test_field);

  // Status update terms: a clear is applied before any set in the same cycle.
  always_comb begin
    status_clear = 1'b0;
    status_set   = {14'd0, test_done, 14'd0};
    case (state)
      DECODE_CS: begin
        if (for_me) begin
          if (op_code == OP_CODE_W_STATUS_FW_CLEAR) begin
            status_clear = 1'b1;
          end else if (exec_bad) begin
            status_set[status_index_error_w_execute_cfg] = 1'b1;
          end
        end
      end
      WAIT_DONE_CS: begin
        if (op_done) begin
          if (op_code == OP_CODE_W_RST_FW) begin
            status_clear = 1'b1;
            status_set[status_index_op_code_w_reset] = 1'b1;
          end else if (op_code == OP_CODE_W_EXECUTE) begin
            status_set[status_index_execute_done] = 1'b1;
          end else begin
            status_set[5'(op_code) - 5'd1] = 1'b1;
          end
        end else if (wait_cnt == TIMEOUT_LAST) begin
          status_set[status_index_error_timeout] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge fw_axi_clk or posedge fw_rst) begin
    if (fw_rst) begin
      state     <= IDLE_CS;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      op_start  <= '0;
      op_body   <= '0;
      dev_id    <= '0;
      op_code   <= '0;
      wait_cnt  <= '0;
      status    <= '0;
    end else begin
      status   <= ((status_clear ? 32'd0 : status) | status_set) & ~STATUS_SPARE_MASK;
      op_start <= '0;
      case (state)
        IDLE_CS: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            dev_id    <= cmd_word[31:28];
            op_code   <= cmd_word[27:24];
            op_body   <= cmd_word[23:0];
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= DECODE_CS;
          end
        end
        DECODE_CS: begin
          if (!for_me || op_code == OP_CODE_NOOP ||
              op_code == OP_CODE_W_STATUS_FW_CLEAR || exec_bad) begin
            state     <= IDLE_CS;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            op_start <= 16'd1 << op_code;
            state    <= ISSUE_CS;
          end
        end
        ISSUE_CS: begin
          wait_cnt <= '0;
          state    <= WAIT_DONE_CS;
        end
        WAIT_DONE_CS: begin
          if (op_done || wait_cnt == TIMEOUT_LAST) begin
            state     <= IDLE_CS;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE_CS;
      endcase
    end
  end

endmodule
